// File: rtl/axi_ram_bridge.sv
// AXI3 slave to single-port word-wide synchronous RAM bridge.
// One transaction in flight at a time; reads and writes share the RAM and are
// granted round-robin. FIXED/INCR/WRAP bursts up to 16 beats, 32-bit data.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for AR/AW; grants one side, latches the request
// RD_ISSUE | RAM read strobe for the current beat address
// RD_RESP  | RAM word presented on R; held until rready
// WR_DATA  | accepting W beats, each written to RAM in its handshake cycle
// WR_RESP  | B response presented until bready

module axi_ram_bridge #(
    parameter int ID_WIDTH = 4,
    parameter int RAM_AW   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ID_WIDTH-1:0] arid,
    input  logic [31:0]         araddr,
    input  logic [7:0]          arlen,
    input  logic [2:0]          arsize,
    input  logic [1:0]          arburst,
    input  logic                arvalid,
    output logic                arready,
    output logic [ID_WIDTH-1:0] rid,
    output logic [31:0]         rdata,
    output logic [1:0]          rresp,
    output logic                rlast,
    output logic                rvalid,
    input  logic                rready,
    input  logic [ID_WIDTH-1:0] awid,
    input  logic [31:0]         awaddr,
    input  logic [7:0]          awlen,
    input  logic [2:0]          awsize,
    input  logic [1:0]          awburst,
    input  logic                awvalid,
    output logic                awready,
    input  logic [31:0]         wdata,
    input  logic [3:0]          wstrb,
    input  logic                wlast,
    input  logic                wvalid,
    output logic                wready,
    output logic [ID_WIDTH-1:0] bid,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready,
    output logic                ram_en,
    output logic [3:0]          ram_we,
    output logic [RAM_AW-1:0]   ram_addr,
    output logic [31:0]         ram_wdata,
    input  logic [31:0]         ram_rdata
);

    typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_RESP, WR_DATA, WR_RESP} state_t;

    state_t              state_q, state_d;
    logic                prio_rd_q;
    logic [ID_WIDTH-1:0] id_q;
    logic [31:0]         addr_q;
    logic [3:0]          len_q;
    logic [2:0]          size_q;
    logic [1:0]          burst_q;
    logic [3:0]          beat_q;
    logic                err_q;

    logic                grant_rd;
    logic                grant_wr;
    logic                last_beat;
    logic [31:0]         step;
    logic [31:0]         wrap_mask;
    logic [31:0]         next_addr;

    // Bursts are at most 16 beats, so the upper length nibble carries nothing.
    logic                unused_len;
    assign unused_len = ^{arlen[7:4], awlen[7:4]};

    assign grant_rd  = arvalid & (~awvalid | prio_rd_q);
    assign grant_wr  = awvalid & ~grant_rd;
    assign last_beat = (beat_q == len_q);
    assign step      = 32'd1 << size_q;
    assign wrap_mask = (({28'd0, len_q} + 32'd1) << size_q) - 32'd1;

    // Next beat address; reserved burst type behaves as INCR.
    always_comb begin
        case (burst_q)
            2'b00:   next_addr = addr_q;
            2'b10:   next_addr = (addr_q & ~wrap_mask) | ((addr_q + step) & wrap_mask);
            default: next_addr = addr_q + step;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_rd)      state_d = RD_ISSUE;
                else if (grant_wr) state_d = WR_DATA;
            end
            RD_ISSUE: state_d = RD_RESP;
            RD_RESP:  if (rready) state_d = last_beat ? IDLE : RD_ISSUE;
            WR_DATA:  if (wvalid && last_beat) state_d = WR_RESP;
            WR_RESP:  if (bready) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Request latching, beat/address tracking, arbitration priority and write error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_rd_q <= 1'b1;
            id_q      <= '0;
            addr_q    <= 32'd0;
            len_q     <= 4'd0;
            size_q    <= 3'd0;
            burst_q   <= 2'b00;
            beat_q    <= 4'd0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_rd | grant_wr) begin
                        id_q      <= grant_rd ? arid    : awid;
                        addr_q    <= grant_rd ? araddr  : awaddr;
                        len_q     <= grant_rd ? arlen[3:0] : awlen[3:0];
                        size_q    <= grant_rd ? arsize  : awsize;
                        burst_q   <= grant_rd ? arburst : awburst;
                        beat_q    <= 4'd0;
                        prio_rd_q <= ~grant_rd;
                    end
                end
                RD_RESP: begin
                    if (rready && !last_beat) begin
                        addr_q <= next_addr;
                        beat_q <= beat_q + 4'd1;
                    end
                end
                WR_DATA: begin
                    if (wvalid) begin
                        addr_q <= next_addr;
                        beat_q <= beat_q + 4'd1;
                        if (wlast != last_beat) err_q <= 1'b1;
                    end
                end
                WR_RESP: if (bready) err_q <= 1'b0;
                default: ;
            endcase
        end
    end

    // Channel handshakes and RAM strobes; everything is forced quiet while rst is high.
    always_comb begin
        arready   = 1'b0;
        awready   = 1'b0;
        rvalid    = 1'b0;
        rlast     = 1'b0;
        rresp     = 2'b00;
        rid       = '0;
        rdata     = ram_rdata;
        wready    = 1'b0;
        bvalid    = 1'b0;
        bresp     = 2'b00;
        bid       = '0;
        ram_en    = 1'b0;
        ram_we    = 4'b0000;
        ram_addr  = addr_q[RAM_AW+1:2];
        ram_wdata = wdata;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    arready = grant_rd;
                    awready = grant_wr;
                end
                RD_ISSUE: ram_en = 1'b1;
                RD_RESP: begin
                    rvalid = 1'b1;
                    rid    = id_q;
                    rlast  = last_beat;
                end
                WR_DATA: begin
                    wready = 1'b1;
                    if (wvalid) begin
                        ram_en = 1'b1;
                        ram_we = wstrb;
                    end
                end
                WR_RESP: begin
                    bvalid = 1'b1;
                    bid    = id_q;
                    bresp  = err_q ? 2'b10 : 2'b00;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/axi_ram_bridge.md
Name: axi_ram_bridge

Overview:
- AXI3 slave that sits directly downstream of the CPU top-level master port and converts its AXI3 traffic into accesses on a single-port, word-wide synchronous RAM.
- Serves the interleaved I-cache refills, D-cache refills, D-cache writebacks and uncached accesses that the CPU arbiter emits.
- Handles one transaction at a time. Reads and writes are arbitrated round-robin.
- Supports FIXED, INCR and WRAP bursts of up to 16 beats, 32-bit data.

Parameters:
- ID_WIDTH, 4, width of arid/rid/awid/bid.
- RAM_AW, 16, RAM word-address width (RAM capacity is 4*2^RAM_AW bytes).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- arid  in  ID_WIDTH; araddr  in  32; arlen  in  8; arsize  in  3; arburst  in  2; arvalid  in  1; arready  out  1
- rid  out  ID_WIDTH; rdata  out  32; rresp  out  2; rlast  out  1; rvalid  out  1; rready  in  1
- awid  in  ID_WIDTH; awaddr  in  32; awlen  in  8; awsize  in  3; awburst  in  2; awvalid  in  1; awready  out  1
- wdata  in  32; wstrb  in  4; wlast  in  1; wvalid  in  1; wready  out  1
- bid  out  ID_WIDTH; bresp  out  2; bvalid  out  1; bready  in  1
- ram_en  out  1  RAM access strobe
- ram_we  out  4  byte write enables; 0 means read
- ram_addr  out  RAM_AW  word address
- ram_wdata  out  32  write data
- ram_rdata  in  32  read data; valid the cycle after ram_en with ram_we=0; RAM holds it while ram_en=0

Behaviour:
- Interface: single clock clk; rst synchronous, active-high.
- Reset:
  - FSM goes to IDLE; priority bit is set to read-first.
  - While rst=1, all ready/valid outputs, ram_en and ram_we are 0.
  - rid, bid, rresp, bresp and rlast reset to 0.
  - A reset mid-burst drops the transaction; no response is issued.
- States: IDLE, RD_ISSUE, RD_RESP, WR_DATA, WR_RESP.
- IDLE grant rules:
  - grant_rd = arvalid & (~awvalid | prio_rd); grant_wr = awvalid & ~grant_rd.
  - arready = IDLE & grant_rd; awready = IDLE & grant_wr. Both are combinational and never high together.
- IDLE latching:
  - On handshake, latch id, addr, len[3:0], size and burst. len[7:4] is ignored.
  - Clear the beat counter.
  - prio_rd <= ~grant_rd, which alternates when both sides contend.
  - Transition to RD_ISSUE or WR_DATA.
- RD_ISSUE: ram_en=1, ram_we=0, ram_addr=cur_addr[RAM_AW+1:2]. Next state RD_RESP.
- RD_RESP:
  - Outputs: rvalid=1, rdata=ram_rdata, rid=latched id, rresp=2'b00, rlast=(beat==len).
  - On rvalid&rready: if last, go to IDLE; else advance the address, increment beat, go to RD_ISSUE.
  - Throughput is 1 beat per 2 cycles. Latency from the AR handshake to the first rvalid is 2 cycles.
  - rvalid stays asserted and rdata stays stable until rready.
- WR_DATA:
  - wready=1.
  - On wvalid: ram_en=1, ram_we=wstrb, ram_wdata=wdata, ram_addr=cur_addr word. This is combinational in the handshake cycle.
  - Then advance the address and increment beat.
  - The burst ends on the beat where beat==len. Then go to WR_RESP.
  - Set err if wlast disagrees with (beat==len) on any beat.
- WR_RESP:
  - Outputs: bvalid=1, bid=latched id, bresp = err ? 2'b10 (SLVERR) : 2'b00.
  - On bready, go to IDLE and clear err.
- Address advance, with step = 1<<size:
  - FIXED (00): address unchanged.
  - INCR (01): addr += step. The full 32 bits wrap modulo 2^32.
  - WRAP (10): boundary = (len+1)*step, where len ∈ {1,3,7,15}. The low bits wrap within an aligned boundary window.
  - Reserved burst type (11): treated as INCR.
- Narrow transfers: rdata is always the full word, and the master selects lanes. Writes rely on wstrb only.
- Address bits above RAM_AW+1 are ignored (aliasing); there is no DECERR.
- ram_en is 0 in every state and cycle not listed above.

Test Plan:
- Single read: arlen=0, araddr=0x10, ram word 4 = 0xDEADBEEF → arready in the same cycle; rvalid, rlast=1, rdata=0xDEADBEEF, rresp=0 two cycles later.
- INCR read: 4 beats from 0x100, rready low on beat 2 for 3 cycles → ram_addr sequence 0x40,0x41,0x42,0x43; beat-2 rdata held stable; rlast only on beat 4.
- WRAP read: 4 beats, size=2, araddr=0x08 → word addresses 2,3,0,1; rid equals arid=0xA.
- Write then read back: 2-beat INCR at 0x200, wstrb 4'b1111 then 4'b0011 → bresp=0; read returns the first word, then the second word with only bytes 0–1 updated.
- Contention: arvalid and awvalid held high from reset → the read is served first, then the write, then the read, alternating. arready and awready are never both high.
- Error/reset: awlen=3 with wlast on beat 2 → bresp=2'b10. In a separate run, assert rst during a read burst at beat 2 → next cycle rvalid=0 and state IDLE, and a subsequent read works normally.
